// File: rtl/noc_vc_merge_pkg.sv
// Shared types and arbitration helper for the two-VC packet merge.
// Fallback values stand in for the Noc_parameters.v shared defines when that file is absent.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif
`ifndef Noc_VC_Channel
`define Noc_VC_Channel 2
`endif
`ifndef NOC_VCM_IDLE
`define NOC_VCM_IDLE 1'b0
`endif
`ifndef NOC_VCM_SEND
`define NOC_VCM_SEND 1'b1
`endif

package noc_vc_merge_pkg;
  localparam int DATA_W = `Noc_Data_Width;
  localparam int NUM_VC = `Noc_VC_Channel;
  localparam int FLIT_W = DATA_W + 2;

  typedef struct packed {
    logic [DATA_W-1:0] flit;
    logic              is_header;
    logic              is_tail;
  } flit_t;

  typedef enum logic {
    VCM_IDLE = `NOC_VCM_IDLE,
    VCM_SEND = `NOC_VCM_SEND
  } vcm_state_e;

  typedef struct packed {
    logic any;
    logic vc;
  } grant_t;

  // When both VCs compete, the one not granted last time wins.
  function automatic grant_t rr_pick(input logic [1:0] elig, input logic last);
    grant_t g;
    g.any = |elig;
    if (&elig) g.vc = ~last;
    else       g.vc = elig[1];
    return g;
  endfunction
endpackage

// File: rtl/noc_flit_fifo.sv
// Synchronous FIFO with extra-MSB pointers; exposes the head entry and the one behind it.
module noc_flit_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] next,
  output logic             has_next,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count, rd_ptr_inc;
  logic             push_ok, pop_ok;

  assign push_ok    = push && !full;
  assign pop_ok     = pop && !empty;
  assign rd_ptr_inc = rd_ptr_reg + PTR_ONE;
  assign count      = wr_ptr_reg - rd_ptr_reg;

  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign has_next = |count[AW:1];
  assign head     = mem[rd_ptr_reg[AW-1:0]];
  assign next     = mem[rd_ptr_inc[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end
endmodule

// File: rtl/noc_vc_merge.sv
// Packet-atomic round-robin merge of two VC flit streams onto one link.
// Define NOC_VC_MERGE_OUTREG_EN to register the sender outputs through a 2-entry skid buffer.
module noc_vc_merge
  import noc_vc_merge_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              noc_clk,
  input  logic              noc_rst_n,
  input  logic              Noc_channel0_receive_valid,
  output logic              Noc_channel0_receive_ready,
  input  logic [DATA_W-1:0] Noc_channel0_receive_flit,
  input  logic              Noc_channel0_receive_is_header,
  input  logic              Noc_channel0_receive_is_tail,
  output logic              Noc_channel0_receive_VCready,
  input  logic              Noc_channel1_receive_valid,
  output logic              Noc_channel1_receive_ready,
  input  logic [DATA_W-1:0] Noc_channel1_receive_flit,
  input  logic              Noc_channel1_receive_is_header,
  input  logic              Noc_channel1_receive_is_tail,
  output logic              Noc_channel1_receive_VCready,
  output logic              Noc_sender_valid,
  input  logic              Noc_sender_ready,
  output logic [DATA_W-1:0] Noc_sender_flit,
  output logic              Noc_sender_is_header,
  output logic              Noc_sender_is_tail,
  output logic              Noc_sender_vc_id
);
  flit_t             wr_flit [NUM_VC];
  flit_t             head    [NUM_VC];
  flit_t             next    [NUM_VC];
  logic [NUM_VC-1:0] in_valid, push, pop, full, empty, has_next;
  logic [NUM_VC-1:0] elig, elig_after, vc_ready;

  vcm_state_e state_reg;
  logic       lock_vc_reg, rr_last_reg;
  logic       lock_valid, take, pop_lock, tail_pop;
  flit_t      lock_head;
  grant_t     grant_idle, grant_tail;

  assign in_valid   = {Noc_channel1_receive_valid, Noc_channel0_receive_valid};
  assign wr_flit[0] = {Noc_channel0_receive_flit, Noc_channel0_receive_is_header,
                       Noc_channel0_receive_is_tail};
  assign wr_flit[1] = {Noc_channel1_receive_flit, Noc_channel1_receive_is_header,
                       Noc_channel1_receive_is_tail};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VC; gi++) begin : g_vc
      noc_flit_fifo #(
        .WIDTH (FLIT_W),
        .DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk      (noc_clk),
        .rst_n    (noc_rst_n),
        .push     (push[gi]),
        .wdata    (wr_flit[gi]),
        .full     (full[gi]),
        .pop      (pop[gi]),
        .head     (head[gi]),
        .next     (next[gi]),
        .has_next (has_next[gi]),
        .empty    (empty[gi])
      );

      assign push[gi] = in_valid[gi] && !full[gi];
      assign pop[gi]  = pop_lock && (lock_vc_reg == 1'(gi));
      assign elig[gi] = !empty[gi] && head[gi].is_header;
      // On a tail pop the locked VC is judged by the entry behind the departing tail.
      assign elig_after[gi] = (lock_vc_reg == 1'(gi)) ? (has_next[gi] && next[gi].is_header)
                                                      : elig[gi];
      assign vc_ready[gi] = empty[gi] && !((state_reg == VCM_SEND) && (lock_vc_reg == 1'(gi)));
    end
  endgenerate

  assign Noc_channel0_receive_ready   = !full[0];
  assign Noc_channel1_receive_ready   = !full[1];
  assign Noc_channel0_receive_VCready = vc_ready[0];
  assign Noc_channel1_receive_VCready = vc_ready[1];

  assign lock_head  = head[lock_vc_reg];
  assign lock_valid = (state_reg == VCM_SEND) && !empty[lock_vc_reg];
  assign pop_lock   = lock_valid && take;
  assign tail_pop   = pop_lock && lock_head.is_tail;
  assign grant_idle = rr_pick(elig, rr_last_reg);
  assign grant_tail = rr_pick(elig_after, rr_last_reg);

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state_reg   <= VCM_IDLE;
      lock_vc_reg <= 1'b0;
      rr_last_reg <= 1'b1;
    end else begin
      case (state_reg)
        VCM_IDLE: begin
          if (grant_idle.any) begin
            lock_vc_reg <= grant_idle.vc;
            rr_last_reg <= grant_idle.vc;
            state_reg   <= VCM_SEND;
          end
        end
        VCM_SEND: begin
          if (tail_pop) begin
            if (grant_tail.any) begin
              lock_vc_reg <= grant_tail.vc;
              rr_last_reg <= grant_tail.vc;
            end else begin
              state_reg <= VCM_IDLE;
            end
          end
        end
      endcase
    end
  end

`ifdef NOC_VC_MERGE_OUTREG_EN
  flit_t out_reg, buf_reg;
  logic  out_valid_reg, out_vc_reg, buf_valid_reg, buf_vc_reg;

  // The locked FIFO may only drain while the spare slot is free.
  assign take = !buf_valid_reg;

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      out_reg       <= '0;
      out_vc_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
      buf_reg       <= '0;
      buf_vc_reg    <= 1'b0;
      buf_valid_reg <= 1'b0;
    end else if (!out_valid_reg || Noc_sender_ready) begin
      if (buf_valid_reg) begin
        out_reg       <= buf_reg;
        out_vc_reg    <= buf_vc_reg;
        out_valid_reg <= 1'b1;
        buf_reg       <= '0;
        buf_vc_reg    <= 1'b0;
        buf_valid_reg <= 1'b0;
      end else if (pop_lock) begin
        out_reg       <= lock_head;
        out_vc_reg    <= lock_vc_reg;
        out_valid_reg <= 1'b1;
      end else begin
        out_reg       <= '0;
        out_vc_reg    <= 1'b0;
        out_valid_reg <= 1'b0;
      end
    end else if (pop_lock) begin
      buf_reg       <= lock_head;
      buf_vc_reg    <= lock_vc_reg;
      buf_valid_reg <= 1'b1;
    end
  end

  assign Noc_sender_valid     = out_valid_reg;
  assign Noc_sender_flit      = out_reg.flit;
  assign Noc_sender_is_header = out_reg.is_header;
  assign Noc_sender_is_tail   = out_reg.is_tail;
  assign Noc_sender_vc_id     = out_vc_reg;
`else
  assign take                 = Noc_sender_ready;
  assign Noc_sender_valid     = lock_valid;
  assign Noc_sender_flit      = lock_valid ? lock_head.flit : '0;
  assign Noc_sender_is_header = lock_valid && lock_head.is_header;
  assign Noc_sender_is_tail   = lock_valid && lock_head.is_tail;
  assign Noc_sender_vc_id     = lock_valid && lock_vc_reg;
`endif
endmodule

// File: tb/tb_noc_vc_merge.sv
// Directed self-checking bench for noc_vc_merge (default build, FIFO_DEPTH=4).
module tb_noc_vc_merge;
  import noc_vc_merge_pkg::*;
  localparam int W = DATA_W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         v0 = 0, h0 = 0, t0 = 0, v1 = 0, h1 = 0, t1 = 0;
  logic [W-1:0] f0 = '0, f1 = '0;
  logic         s_ready = 1'b1;
  logic         rdy0, rdy1, vcr0, vcr1, s_valid, s_hdr, s_tail, s_vc;
  logic [W-1:0] s_flit;
  int           checks = 0;
  int           failures = 0;

  always #5 clk = ~clk;

  noc_vc_merge #(.FIFO_DEPTH(4)) dut (
    .noc_clk                        (clk),
    .noc_rst_n                      (rst_n),
    .Noc_channel0_receive_valid     (v0),
    .Noc_channel0_receive_ready     (rdy0),
    .Noc_channel0_receive_flit      (f0),
    .Noc_channel0_receive_is_header (h0),
    .Noc_channel0_receive_is_tail   (t0),
    .Noc_channel0_receive_VCready   (vcr0),
    .Noc_channel1_receive_valid     (v1),
    .Noc_channel1_receive_ready     (rdy1),
    .Noc_channel1_receive_flit      (f1),
    .Noc_channel1_receive_is_header (h1),
    .Noc_channel1_receive_is_tail   (t1),
    .Noc_channel1_receive_VCready   (vcr1),
    .Noc_sender_valid               (s_valid),
    .Noc_sender_ready               (s_ready),
    .Noc_sender_flit                (s_flit),
    .Noc_sender_is_header           (s_hdr),
    .Noc_sender_is_tail             (s_tail),
    .Noc_sender_vc_id               (s_vc)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packed compare of {valid, header, tail, vc_id, flit}.
  task automatic exp_out(input string tag, input logic v, input logic [W-1:0] f,
                         input logic h, input logic t, input logic vc);
    $display("out %s: valid=%0b flit=%0h hdr=%0b tail=%0b vc=%0b",
             tag, s_valid, s_flit, s_hdr, s_tail, s_vc);
    chk(tag, 64'({s_valid, s_hdr, s_tail, s_vc, s_flit}), 64'({v, h, t, vc, f}));
  endtask

  task automatic drv0(input logic v, input logic [W-1:0] f, input logic h, input logic t);
    v0 = v; f0 = f; h0 = h; t0 = t;
  endtask

  task automatic drv1(input logic v, input logic [W-1:0] f, input logic h, input logic t);
    v1 = v; f1 = f; h1 = h; t1 = t;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    drv0(0, '0, 0, 0);
    drv1(0, '0, 0, 0);
    s_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic         exp_vc;
    logic [W-1:0] exp_f;

    // Reset values
    reset_dut();
    rst_n = 1'b0;
    #1;
    exp_out("rst_out", 0, '0, 0, 0, 0);
    chk("rst_ready", 64'({rdy1, rdy0}), 64'(2'b11));
    chk("rst_vcready", 64'({vcr1, vcr0}), 64'(2'b11));
    tick();
    rst_n = 1'b1;

    // 3-flit packet on VC0
    drv0(1, W'('h11), 1, 0);
    tick();
    drv0(1, W'('h22), 0, 0);
    exp_out("t1_idle", 0, '0, 0, 0, 0);
    chk("t1_vcready0_busy", 64'(vcr0), 64'(0));
    tick();
    drv0(1, W'('h33), 0, 1);
    exp_out("t1_head", 1, W'('h11), 1, 0, 0);
    tick();
    drv0(0, '0, 0, 0);
    exp_out("t1_body", 1, W'('h22), 0, 0, 0);
    tick();
    exp_out("t1_tail", 1, W'('h33), 0, 1, 0);
    tick();
    exp_out("t1_done", 0, '0, 0, 0, 0);
    chk("t1_vcready0_free", 64'(vcr0), 64'(1));

    // Both VCs load a 2-flit packet in the same cycle
    reset_dut();
    drv0(1, W'('hA0), 1, 0);
    drv1(1, W'('hB0), 1, 0);
    tick();
    drv0(1, W'('hA1), 0, 1);
    drv1(1, W'('hB1), 0, 1);
    tick();
    drv0(0, '0, 0, 0);
    drv1(0, '0, 0, 0);
    exp_out("t2_a_head", 1, W'('hA0), 1, 0, 0);
    chk("t2_vcready1_busy", 64'(vcr1), 64'(0));
    tick();
    exp_out("t2_a_tail", 1, W'('hA1), 0, 1, 0);
    tick();
    exp_out("t2_b_head", 1, W'('hB0), 1, 0, 1);
    tick();
    exp_out("t2_b_tail", 1, W'('hB1), 0, 1, 1);
    tick();
    exp_out("t2_idle", 0, '0, 0, 0, 0);

    // Backpressure for 5 cycles while the header is presented
    reset_dut();
    drv0(1, W'('h5A), 1, 0);
    tick();
    drv0(1, W'('h5B), 0, 1);
    s_ready = 1'b0;
    tick();
    drv0(0, '0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      exp_out($sformatf("t3_hold%0d", i), 1, W'('h5A), 1, 0, 0);
      tick();
    end
    s_ready = 1'b1;
    exp_out("t3_head_go", 1, W'('h5A), 1, 0, 0);
    tick();
    exp_out("t3_tail", 1, W'('h5B), 0, 1, 0);
    tick();
    exp_out("t3_idle", 0, '0, 0, 0, 0);

    // Fill VC1 with output stalled; 5th write waits for the first pop
    reset_dut();
    s_ready = 1'b0;
    drv1(1, W'('h41), 1, 0);
    tick();
    drv1(1, W'('h42), 0, 0);
    tick();
    drv1(1, W'('h43), 0, 0);
    tick();
    chk("t4_ready_at3", 64'(rdy1), 64'(1));
    drv1(1, W'('h44), 0, 0);
    tick();
    chk("t4_full", 64'(rdy1), 64'(0));
    drv1(1, W'('h45), 0, 1);
    tick();
    chk("t4_still_full", 64'(rdy1), 64'(0));
    exp_out("t4_f1", 1, W'('h41), 1, 0, 1);
    s_ready = 1'b1;
    tick();
    chk("t4_ready_after_pop", 64'(rdy1), 64'(1));
    exp_out("t4_f2", 1, W'('h42), 0, 0, 1);
    tick();
    drv1(0, '0, 0, 0);
    exp_out("t4_f3", 1, W'('h43), 0, 0, 1);
    tick();
    exp_out("t4_f4", 1, W'('h44), 0, 0, 1);
    tick();
    exp_out("t4_f5", 1, W'('h45), 0, 1, 1);
    tick();
    exp_out("t4_idle", 0, '0, 0, 0, 0);
    chk("t4_vc1_empty", 64'(vcr1), 64'(1));

    // Eight single-flit packets alternating VC0/VC1 with no gaps
    reset_dut();
    for (int k = 0; k < 10; k++) begin
      if (k < 4) begin
        drv0(1, W'('hC0 + k), 1, 1);
        drv1(1, W'('hD0 + k), 1, 1);
      end else begin
        drv0(0, '0, 0, 0);
        drv1(0, '0, 0, 0);
      end
      tick();
      if (k >= 1 && k <= 8) begin
        exp_vc = 1'((k - 1) % 2);
        exp_f  = exp_vc ? W'('hD0 + (k - 1) / 2) : W'('hC0 + (k - 1) / 2);
        exp_out($sformatf("t5_pkt%0d", k - 1), 1, exp_f, 1, 1, exp_vc);
      end else if (k == 9) begin
        exp_out("t5_idle", 0, '0, 0, 0, 0);
      end
    end

    // Reset mid-packet on VC0, then a clean VC1 packet
    reset_dut();
    drv0(1, W'('h71), 1, 0);
    tick();
    drv0(1, W'('h72), 0, 0);
    tick();
    drv0(0, '0, 0, 0);
    exp_out("t6_pre_reset", 1, W'('h71), 1, 0, 0);
    rst_n = 1'b0;
    #1;
    exp_out("t6_in_reset", 0, '0, 0, 0, 0);
    chk("t6_vcready0", 64'(vcr0), 64'(1));
    tick();
    tick();
    rst_n = 1'b1;
    drv1(1, W'('h81), 1, 0);
    tick();
    drv1(1, W'('h82), 0, 1);
    tick();
    drv1(0, '0, 0, 0);
    exp_out("t6_b_head", 1, W'('h81), 1, 0, 1);
    chk("t6_vc0_empty", 64'(vcr0), 64'(1));
    tick();
    exp_out("t6_b_tail", 1, W'('h82), 0, 1, 1);
    tick();
    exp_out("t6_idle", 0, '0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/noc_vc_merge.md
# noc_vc_merge

Packet-atomic merge of two virtual-channel flit streams onto one physical NoC link, sitting at a router output port upstream of the link driver. Each VC has a small input FIFO. A round-robin arbiter grants the link to one VC for a whole packet, header through tail, and tags every output flit with its VC id. Per-VC `VCready` reports when a VC can take a new packet, which upstream VC-allocation logic uses to pick a target channel.

## Interface
- `FIFO_DEPTH`, default 4: per-VC FIFO depth. Power of two, ≥2.
- Shared defines: `` `Noc_Data_Width `` for flit width; `` `Noc_VC_Channel `` = 2.

Ports:
- `noc_clk` input 1: single clock, rising edge.
- `noc_rst_n` input 1: asynchronous, active-low reset.
- `Noc_channel{0,1}_receive_valid` input 1: flit valid on VC n.
- `Noc_channel{0,1}_receive_ready` output 1: VC n FIFO not full.
- `Noc_channel{0,1}_receive_flit` input `` `Noc_Data_Width ``: flit payload.
- `Noc_channel{0,1}_receive_is_header` input 1: flit is the packet's first flit.
- `Noc_channel{0,1}_receive_is_tail` input 1: flit is the packet's last flit.
- `Noc_channel{0,1}_receive_VCready` output 1: VC n FIFO empty and VC n not locked.
- `Noc_sender_valid` output 1: output flit valid.
- `Noc_sender_ready` input 1: link accepts flit.
- `Noc_sender_flit` output `` `Noc_Data_Width ``: output payload.
- `Noc_sender_is_header`, `Noc_sender_is_tail` output 1: framing bits, carried through from the input flit.
- `Noc_sender_vc_id` output 1: source VC of the current flit.

## Operation
- **Write side.** A flit enters VC n's FIFO on `valid && ready`. Each entry stores {flit, is_header, is_tail}.
- **Write blocking.** `ready` = !full. There is no write-through-on-read when full.
- **FSM states.** `IDLE` and `SEND`. Registers: `lock_vc`, and `rr_last` (VC granted most recently; reset 1, so VC0 wins first).
- **Eligibility.** A VC is eligible when its FIFO is non-empty and its head has `is_header`=1.
  - A non-header head is never eligible in `IDLE`. Upstream guarantees correct framing; violations stall that VC and are not flagged.
- **Grant.** If both VCs are eligible, the VC ≠ `rr_last` wins.
- **IDLE.** If any VC is eligible: `lock_vc` ← winner, `rr_last` ← winner, go to `SEND`. Outputs are not valid in `IDLE`.
- **SEND.**
  - `Noc_sender_valid` = locked FIFO non-empty.
  - Payload and framing outputs = locked FIFO head; `vc_id` = `lock_vc`.
  - The FIFO pops on `valid && Noc_sender_ready`.
- **Tail handshake in SEND.** Re-arbitrate in the same cycle, excluding the just-popped tail entry.
  - If any VC is eligible, stay in `SEND` with the new lock (back-to-back packets, no bubble).
  - Otherwise go to `IDLE`.
- **Single-flit packets.** A flit with header=tail=1 is valid and occupies `SEND` for exactly one handshake.
- **Mid-packet starvation.** If the locked FIFO empties mid-packet, `valid` drops. The lock holds, and the other VC is never interleaved.
- **Output hold.** Outputs not valid drive flit, framing and `vc_id` to 0.
- **Reset.** All FIFOs empty, state `IDLE`, `lock_vc`=0, `rr_last`=1. Reset mid-packet discards all buffered flits.
- **Reset values of outputs.**
  - `receive_ready`=1 and `VCready`=1 on both VCs.
  - `Noc_sender_valid`=0, `flit`=0, `is_header`=0, `is_tail`=0, `vc_id`=0.

## Timing
- A header written at edge t is at the FIFO head at t+1. `IDLE` grants at t+1; `SEND` outputs it valid from t+2.
- **Streaming.** Within a packet, or across packets via the tail re-arbitration, one flit per cycle while `Noc_sender_ready`=1.
- **Backpressure.** While `Noc_sender_ready`=0, outputs hold stable; valid is not withdrawn.
- **Simultaneous push and pop on one FIFO.** Both happen; occupancy is unchanged.
- **Pointers.** log2(`FIFO_DEPTH`)+1 bits; full/empty decided by MSB compare; wrap is natural.
- **VCready.** Combinational from registered state. It deasserts the cycle after a write to an empty FIFO, or when that VC becomes locked.

## Configuration
- Macro: `NOC_VC_MERGE_OUTREG_EN`.
- **Defined.** A 2-entry skid buffer registers all `Noc_sender_*` outputs.
  - Latency becomes t+3; throughput stays 1 flit/cycle.
  - Outputs are driven from flops; the skid buffer's reset value is empty/0.
  - A pop from the locked FIFO happens when the skid buffer can accept.
- **Undefined.** Outputs are combinational from the FIFO head as described above.

## Structure
- Shared defines come from `Noc_parameters.v`: `` `Noc_Data_Width ``, `` `Noc_VC_Channel ``, and new state encodings `` `NOC_VCM_IDLE `` and `` `NOC_VCM_SEND ``.
- One sub-module, `noc_flit_fifo`: synchronous FIFO parameterised by width and depth, with full/empty outputs. It is instantiated twice.
- The arbiter FSM and optional skid buffer live in the top module.

## Test plan
- Reset, then one 3-flit packet on VC0 (H payload 0x11, body 0x22, T 0x33); sender_ready=1 → flits out on cycles t+2..t+4, vc_id=0, `VCready0` back to 1 after the tail.
- Both VCs load a 2-flit packet in the same cycle → VC0 packet first, then VC1 with no gap; flits never interleaved.
- 2-flit packet with `Noc_sender_ready`=0 for 5 cycles mid-packet → header output stable for all 5 cycles; no flit lost or duplicated.
- Write 5 flits into VC1 with output stalled, `FIFO_DEPTH`=4 → `receive_ready1`=0 after 4 writes; 5th accepted only after the first pop.
- Single-flit packets (H=T=1) alternating VC0/VC1 for 8 packets → 8 consecutive output flits with vc_id alternating 0,1,0,1…
- Reset asserted mid-packet on VC0 → outputs 0 immediately; after release, the FIFO is empty and a new VC1 packet is output correctly.
